// File: rtl/branch_scoreboard_pkg.sv
// Shared definitions for the branch scoreboard.
//   REG_W   : register index width
//   CNT_W   : width of each per-register pending counter
//   NREGS   : registers per file
//   CNT_MAX : counter value at which new issues to that register must hold
//   ex_tag_t: record of the instruction currently in EX that bumped a counter
package branch_scoreboard_pkg;

    localparam int REG_W   = 5;
    localparam int CNT_W   = 2;
    localparam int NREGS   = 32;
    localparam int STALL_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             fp;
    } ex_tag_t;

    // Integer x0 is never tracked; float destinations (f0 included) are
    // tracked only when the float file exists.
    function automatic logic is_tracked(input logic fp, input logic [REG_W-1:0] rd,
                                        input logic float_en);
        return fp ? float_en : (rd != '0);
    endfunction

endpackage

// File: rtl/branch_scoreboard_if.sv
// Pipeline <-> scoreboard signal bundle.
//   master: pipeline side (drives issue/flush/writeback/branch operands)
//   slave : scoreboard side (drives br_stall, issue_block, sb_err, stall_cnt)
// Transfer rule: an issue is accepted on a rising edge when
// pipe_en & issue_valid & !issue_block & !flush; issue_block is the only
// back-pressure and depends solely on issue_rd/issue_fp, never on issue_valid.
interface branch_scoreboard_if;
    import branch_scoreboard_pkg::*;

    logic               pipe_en;
    logic               issue_valid;
    logic               issue_wb;
    logic               issue_fp;
    logic [REG_W-1:0]   issue_rd;
    logic               flush;
    logic               wbwb;
    logic               fw_wb;
    logic [REG_W-1:0]   rdwb;
    logic [REG_W-1:0]   rs1id;
    logic [REG_W-1:0]   rs2id;
    logic [1:0]         float_read;
    logic               br_stall;
    logic               issue_block;
    logic               sb_err;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        output pipe_en, issue_valid, issue_wb, issue_fp, issue_rd, flush,
               wbwb, fw_wb, rdwb, rs1id, rs2id, float_read,
        input  br_stall, issue_block, sb_err, stall_cnt
    );

    modport slave (
        input  pipe_en, issue_valid, issue_wb, issue_fp, issue_rd, flush,
               wbwb, fw_wb, rdwb, rs1id, rs2id, float_read,
        output br_stall, issue_block, sb_err, stall_cnt
    );

endinterface

// File: rtl/branch_scoreboard_sb_counter.sv
// sb_counter: one register's pending-write counter.
//   inc       : an instruction writing this register was issued
//   dec_a     : retire (writeback) of this register
//   dec_b     : retract of a flushed EX instruction writing this register
//   cnt       : current pending count
//   underflow : this cycle's decrements exceed count + increment
// All three events combine arithmetically in one cycle.
module sb_counter
    import branch_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec_a,
    input  logic             dec_b,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);

    logic [CNT_W:0] up;
    logic [CNT_W:0] down;
    logic [CNT_W:0] next;

    assign up        = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
    assign down      = {{CNT_W{1'b0}}, dec_a} + {{CNT_W{1'b0}}, dec_b};
    assign underflow = (down > up);
    assign next      = up - down;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (underflow) begin
            cnt <= '0;
        end else if (next > {1'b0, CNT_MAX}) begin
            // Unreachable while issue_block gates increments; kept as a guard.
            cnt <= CNT_MAX;
        end else begin
            cnt <= next[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/branch_scoreboard.sv
// branch_scoreboard: tracks pending register writes so a branch in ID can
// tell whether its operands are available (directly or via WB bypass).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of branch_scoreboard_if
//              (issue, flush, writeback, branch operands in;
//               br_stall, issue_block, sb_err, stall_cnt out)
//   FLOAT    : 1 adds a separate float register-file scoreboard
module branch_scoreboard
    import branch_scoreboard_pkg::*;
#(
    parameter int FLOAT = 0
) (
    input  logic               clk,
    input  logic               rst,
    branch_scoreboard_if.slave bus
);

    localparam logic FLOAT_EN = (FLOAT != 0);

    logic [CNT_W-1:0]      cnt [2][NREGS];
    logic [1:0][NREGS-1:0] uf_v;
    ex_tag_t               ex_tag;
    logic                  issue_tracked;
    logic                  blocked;
    logic                  do_inc;
    logic                  retire;
    logic                  retract;
    logic                  rs1_pend;
    logic                  rs2_pend;
    logic                  br_stall;
    logic                  sb_err_q;
    logic [STALL_W-1:0]    stall_cnt_q;

    assign issue_tracked = is_tracked(bus.issue_fp, bus.issue_rd, FLOAT_EN);
    assign blocked       = issue_tracked && (cnt[bus.issue_fp][bus.issue_rd] == CNT_MAX);
    assign do_inc        = bus.pipe_en && bus.issue_valid && bus.issue_wb && !bus.flush
                           && !blocked && issue_tracked;
    assign retire        = bus.wbwb && is_tracked(bus.fw_wb, bus.rdwb, FLOAT_EN);
    // A valid tag always names a tracked register, so no extra check here.
    assign retract       = bus.flush && ex_tag.valid;

    for (genvar f = 0; f < 2; f++) begin : g_file
        for (genvar r = 0; r < NREGS; r++) begin : g_reg
            if (f == 0 || FLOAT_EN) begin : g_cnt
                logic inc;
                logic ret;
                logic rtr;
                assign inc = do_inc && (bus.issue_fp == 1'(f)) && (bus.issue_rd == REG_W'(r));
                assign ret = retire && (bus.fw_wb == 1'(f)) && (bus.rdwb == REG_W'(r));
                assign rtr = retract && (ex_tag.fp == 1'(f)) && (ex_tag.rd == REG_W'(r));
                sb_counter u_cnt (
                    .clk       (clk),
                    .rst       (rst),
                    .inc       (inc),
                    .dec_a     (ret),
                    .dec_b     (rtr),
                    .cnt       (cnt[f][r]),
                    .underflow (uf_v[f][r])
                );
            end else begin : g_none
                assign cnt[f][r]  = '0;
                assign uf_v[f][r] = 1'b0;
            end
        end
    end

    // A count of exactly one whose write retires this cycle is covered by
    // the WB bypass, so it does not stall the branch.
    assign rs1_pend = (cnt[bus.float_read[1]][bus.rs1id] != '0) &&
                      !((cnt[bus.float_read[1]][bus.rs1id] == CNT_W'(1)) && retire &&
                        (bus.fw_wb == bus.float_read[1]) && (bus.rdwb == bus.rs1id));
    assign rs2_pend = (cnt[bus.float_read[0]][bus.rs2id] != '0) &&
                      !((cnt[bus.float_read[0]][bus.rs2id] == CNT_W'(1)) && retire &&
                        (bus.fw_wb == bus.float_read[0]) && (bus.rdwb == bus.rs2id));
    assign br_stall = rs1_pend || rs2_pend;

    // EX tag follows the instruction moving ID->EX; a flush without a
    // transfer just kills whatever is sitting in EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_tag <= '0;
        end else if (bus.pipe_en) begin
            ex_tag <= '{valid: do_inc, rd: bus.issue_rd, fp: bus.issue_fp};
        end else if (bus.flush) begin
            ex_tag.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (|uf_v) begin
                sb_err_q <= 1'b1;
            end
            if (br_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STALL_W'(1);
            end
        end
    end

    assign bus.br_stall    = br_stall;
    assign bus.issue_block = blocked;
    assign bus.sb_err      = sb_err_q;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_branch_scoreboard.sv
// Bench for branch_scoreboard: a FLOAT=1 and a FLOAT=0 instance share the
// same stimulus; both are compared every cycle against a count-based model.
module tb_branch_scoreboard;
    import branch_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_scoreboard_if bus1 ();
    branch_scoreboard_if bus0 ();

    branch_scoreboard #(.FLOAT(1)) dut_f (.clk(clk), .rst(rst), .bus(bus1));
    branch_scoreboard #(.FLOAT(0)) dut_i (.clk(clk), .rst(rst), .bus(bus0));

    assign bus0.pipe_en     = bus1.pipe_en;
    assign bus0.issue_valid = bus1.issue_valid;
    assign bus0.issue_wb    = bus1.issue_wb;
    assign bus0.issue_fp    = bus1.issue_fp;
    assign bus0.issue_rd    = bus1.issue_rd;
    assign bus0.flush       = bus1.flush;
    assign bus0.wbwb        = bus1.wbwb;
    assign bus0.fw_wb       = bus1.fw_wb;
    assign bus0.rdwb        = bus1.rdwb;
    assign bus0.rs1id       = bus1.rs1id;
    assign bus0.rs2id       = bus1.rs2id;
    assign bus0.float_read  = bus1.float_read;

    int total = 0;
    int bad   = 0;
    logic [18:0] exp_q[$];

    // ---------------- reference model (index 1: FLOAT=1, 0: FLOAT=0) ----
    int mc [2][2][32];
    bit m_err [2];
    int m_scnt [2];
    bit tv [2];
    int trd [2];
    bit tfp [2];

    function automatic bit trk(int d, bit fp, int rd);
        if (fp) return d == 1;
        return rd != 0;
    endfunction

    function automatic bit m_block(int d);
        int rd = int'(bus1.issue_rd);
        bit fp = bus1.issue_fp;
        return trk(d, fp, rd) && mc[d][fp][rd] == 3;
    endfunction

    function automatic bit m_pend(int d, int rs, bit fp);
        int c = mc[d][fp][rs];
        bit byp = bus1.wbwb && trk(d, bus1.fw_wb, int'(bus1.rdwb)) &&
                  bus1.fw_wb == fp && int'(bus1.rdwb) == rs;
        return c != 0 && !(c == 1 && byp);
    endfunction

    function automatic bit m_stall(int d);
        return m_pend(d, int'(bus1.rs1id), bus1.float_read[1]) ||
               m_pend(d, int'(bus1.rs2id), bus1.float_read[0]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int f = 0; f < 2; f++)
                for (int r = 0; r < 32; r++) mc[d][f][r] = 0;
            m_err[d] = 0; m_scnt[d] = 0; tv[d] = 0; trd[d] = 0; tfp[d] = 0;
        end
    endtask

    task automatic model_tick();
        for (int d = 0; d < 2; d++) begin
            int delta [2][32];
            bit inc;
            bit stall;
            int v;
            int rd = int'(bus1.issue_rd);
            int rw = int'(bus1.rdwb);
            stall = m_stall(d);
            for (int f = 0; f < 2; f++)
                for (int r = 0; r < 32; r++) delta[f][r] = 0;
            inc = bus1.pipe_en && bus1.issue_valid && bus1.issue_wb && !bus1.flush &&
                  !m_block(d) && trk(d, bus1.issue_fp, rd);
            if (inc) delta[bus1.issue_fp][rd] += 1;
            if (bus1.wbwb && trk(d, bus1.fw_wb, rw)) delta[bus1.fw_wb][rw] -= 1;
            if (bus1.flush && tv[d]) delta[tfp[d]][trd[d]] -= 1;
            for (int f = 0; f < 2; f++)
                for (int r = 0; r < 32; r++) begin
                    v = mc[d][f][r] + delta[f][r];
                    if (v < 0) begin v = 0; m_err[d] = 1; end
                    if (v > 3) v = 3;
                    mc[d][f][r] = v;
                end
            if (stall && m_scnt[d] < 65535) m_scnt[d]++;
            if (bus1.pipe_en) begin
                tv[d] = inc; trd[d] = rd; tfp[d] = bus1.issue_fp;
            end else if (bus1.flush) begin
                tv[d] = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        logic [18:0] e;
        exp_q.push_back({m_block(1), m_stall(1), m_err[1], 16'(m_scnt[1])});
        exp_q.push_back({m_block(0), m_stall(0), m_err[0], 16'(m_scnt[0])});
        e = exp_q.pop_front();
        chk({tag, " block_f"}, 32'(bus1.issue_block), 32'(e[18]));
        chk({tag, " stall_f"}, 32'(bus1.br_stall), 32'(e[17]));
        chk({tag, " err_f"},   32'(bus1.sb_err), 32'(e[16]));
        chk({tag, " scnt_f"},  32'(bus1.stall_cnt), 32'(e[15:0]));
        e = exp_q.pop_front();
        chk({tag, " block_i"}, 32'(bus0.issue_block), 32'(e[18]));
        chk({tag, " stall_i"}, 32'(bus0.br_stall), 32'(e[17]));
        chk({tag, " err_i"},   32'(bus0.sb_err), 32'(e[16]));
        chk({tag, " scnt_i"},  32'(bus0.stall_cnt), 32'(e[15:0]));
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(string tag);
        @(negedge clk);
        check_model(tag);
        tick();
    endtask

    // ---------------- drivers ----------------
    task automatic drive(bit pe, bit iv, bit iw, bit fp, int rd, bit fl,
                         bit wb, bit fw, int rdwb, int rs1, int rs2, int fr);
        bus1.pipe_en = pe; bus1.issue_valid = iv; bus1.issue_wb = iw;
        bus1.issue_fp = fp; bus1.issue_rd = rd[4:0]; bus1.flush = fl;
        bus1.wbwb = wb; bus1.fw_wb = fw; bus1.rdwb = rdwb[4:0];
        bus1.rs1id = rs1[4:0]; bus1.rs2id = rs2[4:0]; bus1.float_read = fr[1:0];
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset between edges: outputs must clear without a clock.
    task automatic do_reset(string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, " rst stall_f"}, 32'(bus1.br_stall), 0);
        chk({tag, " rst block_f"}, 32'(bus1.issue_block), 0);
        chk({tag, " rst err_f"},   32'(bus1.sb_err), 0);
        chk({tag, " rst scnt_f"},  32'(bus1.stall_cnt), 0);
        chk({tag, " rst err_i"},   32'(bus0.sb_err), 0);
        chk({tag, " rst scnt_i"},  32'(bus0.stall_cnt), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        bit pe, iv, iw, fp; int rd; bit fl, wb, fw; int rdwb, rs1, rs2, fr;
        bit es, eb, ee;
    } vec_t;
    vec_t vecs[$];

    task automatic add(bit pe, bit iv, bit iw, bit fp, int rd, bit fl, bit wb, bit fw,
                       int rdwb, int rs1, int rs2, int fr, bit es, bit eb, bit ee);
        vec_t v;
        v.pe = pe; v.iv = iv; v.iw = iw; v.fp = fp; v.rd = rd; v.fl = fl;
        v.wb = wb; v.fw = fw; v.rdwb = rdwb; v.rs1 = rs1; v.rs2 = rs2; v.fr = fr;
        v.es = es; v.eb = eb; v.ee = ee;
        vecs.push_back(v);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_model("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        //   pe iv iw fp rd fl wb fw rdwb rs1 rs2 fr  stall block err
        add(1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // issue x5
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0);   // branch on x5
        add(0, 0, 0, 0, 0, 0, 1, 0, 5, 5, 0, 0, 0, 0, 0);   // WB bypass of x5
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);   // x5 now free
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // issue x0
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // x7 x3
        add(1, 1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 7, 0, 0, 0, 0, 7, 0, 0, 1, 1, 0);   // saturated
        add(1, 1, 1, 0, 7, 0, 1, 0, 7, 0, 0, 0, 0, 1, 0);   // blocked issue + retire
        add(0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // count 2: unblocked
        add(0, 0, 0, 0, 7, 0, 0, 0, 0, 7, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 7, 7, 0, 0, 1, 0, 0);   // retire at 2: still pending
        add(0, 0, 0, 0, 0, 0, 1, 0, 7, 7, 0, 0, 0, 0, 0);   // retire at 1: bypass
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // issue x9
        add(1, 1, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // flush + reissue x9
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 0, 0);
        add(1, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // issue f3
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);   // int x3 read
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 2, 1, 0, 0);   // float rs1
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0);   // float rs2
        add(0, 0, 0, 0, 0, 0, 1, 1, 3, 3, 0, 2, 0, 0, 0);   // f3 bypass
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 2, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0, 0, 0);   // retire idle x4
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // sticky error

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].pe, vecs[i].iv, vecs[i].iw, vecs[i].fp, vecs[i].rd, vecs[i].fl,
                  vecs[i].wb, vecs[i].fw, vecs[i].rdwb, vecs[i].rs1, vecs[i].rs2, vecs[i].fr);
            @(negedge clk);
            chk($sformatf("vec%0d stall", i), 32'(bus1.br_stall), 32'(vecs[i].es));
            chk($sformatf("vec%0d block", i), 32'(bus1.issue_block), 32'(vecs[i].eb));
            chk($sformatf("vec%0d err", i),   32'(bus1.sb_err), 32'(vecs[i].ee));
            check_model($sformatf("vec%0d", i));
            tick();
        end

        // Saturate x7, then reset asynchronously: pending state must vanish.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
            cyc("fill7");
        end
        drive(0, 0, 0, 0, 7, 0, 0, 0, 0, 7, 0, 0);
        @(negedge clk);
        chk("pre-rst block7", 32'(bus1.issue_block), 1);
        chk("pre-rst stall7", 32'(bus1.br_stall), 1);
        do_reset("mid");
        @(negedge clk);
        check_model("post-rst");
        tick();

        // Randomised traffic on a small register window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            int rdw, need;
            bit fw;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 15) == 0,
                  0, 0, 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
            fw  = ($urandom_range(0, 3) == 0);
            rdw = $urandom_range(0, 7);
            need = 1 + ((tv[1] && tfp[1] == fw && trd[1] == rdw) ? 1 : 0);
            if ($urandom_range(0, 1) == 1 && (mc[1][fw][rdw] >= need || !trk(1, fw, rdw))) begin
                bus1.wbwb = 1'b1; bus1.fw_wb = fw; bus1.rdwb = rdw[4:0];
            end
            cyc("rand");
        end

        // Retire of an instruction issued before a reset must flag an error.
        drive(1, 1, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0);
        cyc("pre6");
        idle();
        do_reset("late");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0, 0);
        cyc("stale6");
        idle();
        cyc("stale6b");
        chk("stale err_f", 32'(bus1.sb_err), 1);
        chk("stale err_i", 32'(bus0.sb_err), 1);

        // Long stall to saturate stall_cnt.
        drive(1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        cyc("hold5");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        repeat (70000) cyc("hold");
        chk("sat scnt_f", 32'(bus1.stall_cnt), 32'h0000FFFF);
        chk("sat scnt_i", 32'(bus0.stall_cnt), 32'h0000FFFF);
        chk("sat stall_f", 32'(bus1.br_stall), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
